rr_priority_arbiter: RTL and testbench

- Parametrised, registered N-way arbiter. It is the sequential successor to the team's combinational priority encoder.
- Takes N level-sensitive request lines and issues one held grant. The grant is available as a one-hot vector, an encoded index and a valid flag.
- Two modes: fixed priority (lowest index wins) or round-robin. Round-robin has an optional hold-limit counter for fairness.
- Sits between multiple bus masters/channels and a shared resource.

---
 rtl/rr_priority_arbiter.sv | 115 +++++++++++
 tb/tb_rr_priority_arbiter.sv | 195 +++++++++++++++++++
 2 files changed

// File: rtl/rr_priority_arbiter.sv
// Registered N-way arbiter: fixed priority or round-robin with an optional
// hold limit that forces rotation when other requesters are waiting.
module rr_priority_arbiter #(
  parameter int N        = 8,
  parameter int IDXW     = $clog2(N),
  parameter int RR_MODE  = 1,
  parameter int MAX_HOLD = 4,
  localparam int HW      = (MAX_HOLD > 0) ? $clog2(MAX_HOLD + 1) : 1
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic [N-1:0]    req,
  output logic [N-1:0]    gnt,
  output logic [IDXW-1:0] gnt_idx,
  output logic            gnt_valid,
  output logic [HW-1:0]   hold_cnt
);

  // state | meaning
  // IDLE  | no owner, gnt=0, gnt_idx=0, hold_cnt=0
  // GRANT | requester gnt_idx owns the resource for hold_cnt cycles
  localparam logic [0:0] IDLE  = 1'b0;
  localparam logic [0:0] GRANT = 1'b1;

  localparam int              HOLD_SAT = (MAX_HOLD > 0) ? MAX_HOLD : 1;
  localparam logic [HW-1:0]   HOLD_TOP = HW'(HOLD_SAT);
  localparam logic [IDXW:0]   N_W      = (IDXW + 1)'(N);
  localparam logic [IDXW-1:0] LAST_IDX = IDXW'(N - 1);

  logic [0:0]      state;
  logic [IDXW-1:0] last;
  logic [N-1:0]    arb_vec;
  logic            others;
  logic [IDXW-1:0] start;
  logic [IDXW:0]   sum;
  logic            found;
  logic [IDXW-1:0] win;
  logic            keep;

  logic [0:0]      state_n;
  logic [N-1:0]    gnt_n;
  logic [IDXW-1:0] idx_n;
  logic [HW-1:0]   hold_n;
  logic [IDXW-1:0] last_n;

  // Masking with the current grant excludes the owner on forced rotation and
  // is a no-op once the owner has dropped its request.
  always_comb begin
    arb_vec = req & ~gnt;
    others  = |arb_vec;
    if (RR_MODE != 0) start = (last == LAST_IDX) ? '0 : last + 1'b1;
    else              start = '0;
    found = 1'b0;
    win   = '0;
    sum   = '0;
    for (int k = 0; k < N; k++) begin
      sum = {1'b0, start} + (IDXW + 1)'(k);
      if (sum >= N_W) sum = sum - N_W;
      if (!found && arb_vec[sum[IDXW-1:0]]) begin
        found = 1'b1;
        win   = sum[IDXW-1:0];
      end
    end
  end

  always_comb begin
    keep = 1'b0;
    if (state == GRANT && req[gnt_idx]) begin
      if (RR_MODE == 0 || MAX_HOLD == 0 || hold_cnt < HOLD_TOP || !others)
        keep = 1'b1;
    end
  end

  always_comb begin
    state_n = state;
    gnt_n   = gnt;
    idx_n   = gnt_idx;
    hold_n  = hold_cnt;
    last_n  = last;
    if (keep) begin
      if (hold_cnt != HOLD_TOP) hold_n = hold_cnt + 1'b1;
    end else if (found) begin
      state_n    = GRANT;
      gnt_n      = '0;
      gnt_n[win] = 1'b1;
      idx_n      = win;
      hold_n     = HW'(1);
      last_n     = win;
    end else begin
      state_n = IDLE;
      gnt_n   = '0;
      idx_n   = '0;
      hold_n  = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state    <= IDLE;
      gnt      <= '0;
      gnt_idx  <= '0;
      hold_cnt <= '0;
      last     <= LAST_IDX;
    end else begin
      state    <= state_n;
      gnt      <= gnt_n;
      gnt_idx  <= idx_n;
      hold_cnt <= hold_n;
      last     <= last_n;
    end
  end

  assign gnt_valid = (state == GRANT);

endmodule

// File: tb/tb_rr_priority_arbiter.sv
// Scoreboard bench for rr_priority_arbiter: directed vectors on four
// configurations, then random requests with per-cycle invariant checks.
module tb_rr_priority_arbiter;

  logic       clk;
  logic       rst_n;
  logic [7:0] req_fp, req_r0, req_r4;
  logic [4:0] req_r5;

  logic [7:0] gnt_fp, gnt_r0, gnt_r4;
  logic [4:0] gnt_r5;
  logic [2:0] idx_fp, idx_r0, idx_r4, idx_r5;
  logic       val_fp, val_r0, val_r4, val_r5;
  logic [2:0] hold_fp, hold_r4;
  logic       hold_r0, hold_r5;

  rr_priority_arbiter #(.N(8), .RR_MODE(0), .MAX_HOLD(4)) u_fp (
    .clk(clk), .rst_n(rst_n), .req(req_fp), .gnt(gnt_fp),
    .gnt_idx(idx_fp), .gnt_valid(val_fp), .hold_cnt(hold_fp));
  rr_priority_arbiter #(.N(8), .RR_MODE(1), .MAX_HOLD(0)) u_r0 (
    .clk(clk), .rst_n(rst_n), .req(req_r0), .gnt(gnt_r0),
    .gnt_idx(idx_r0), .gnt_valid(val_r0), .hold_cnt(hold_r0));
  rr_priority_arbiter #(.N(8), .RR_MODE(1), .MAX_HOLD(4)) u_r4 (
    .clk(clk), .rst_n(rst_n), .req(req_r4), .gnt(gnt_r4),
    .gnt_idx(idx_r4), .gnt_valid(val_r4), .hold_cnt(hold_r4));
  rr_priority_arbiter #(.N(5), .RR_MODE(1), .MAX_HOLD(0)) u_r5 (
    .clk(clk), .rst_n(rst_n), .req(req_r5), .gnt(gnt_r5),
    .gnt_idx(idx_r5), .gnt_valid(val_r5), .hold_cnt(hold_r5));

  logic [7:0] o_gnt  [4];
  logic [2:0] o_idx  [4];
  logic       o_val  [4];
  logic [2:0] o_hold [4];
  logic [7:0] o_req  [4];

  assign o_gnt[0] = gnt_fp;           assign o_gnt[1] = gnt_r0;
  assign o_gnt[2] = gnt_r4;           assign o_gnt[3] = {3'b0, gnt_r5};
  assign o_idx[0] = idx_fp;           assign o_idx[1] = idx_r0;
  assign o_idx[2] = idx_r4;           assign o_idx[3] = idx_r5;
  assign o_val[0] = val_fp;           assign o_val[1] = val_r0;
  assign o_val[2] = val_r4;           assign o_val[3] = val_r5;
  assign o_hold[0] = hold_fp;         assign o_hold[1] = {2'b0, hold_r0};
  assign o_hold[2] = hold_r4;         assign o_hold[3] = {2'b0, hold_r5};
  assign o_req[0] = req_fp;           assign o_req[1] = req_r0;
  assign o_req[2] = req_r4;           assign o_req[3] = {3'b0, req_r5};

  typedef struct {
    int         sel;
    logic [7:0] gnt;
    logic [2:0] idx;
    logic       valid;
    logic [2:0] hold;
  } exp_t;

  exp_t sb[$];
  exp_t mon_e;
  int   checks;
  int   errors;
  logic inv_on;
  logic [7:0] req_snap [4];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string nm, input int d, input logic [7:0] act, input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s dut%0d t=%0t: got %h expected %h", nm, d, $time, act, exp);
    end
  endtask

  // One stimulus cycle: drive inputs, queue the response expected after the next edge.
  task automatic step(input int sel, input logic rstv, input logic [7:0] r,
                      input logic ev, input logic [2:0] ei, input logic [2:0] eh);
    exp_t e;
    @(negedge clk);
    rst_n = rstv;
    case (sel)
      0:       req_fp = r;
      1:       req_r0 = r;
      2:       req_r4 = r;
      default: req_r5 = r[4:0];
    endcase
    e.sel   = sel;
    e.valid = ev;
    e.idx   = ei;
    e.hold  = eh;
    e.gnt   = ev ? (8'h01 << ei) : 8'h00;
    sb.push_back(e);
  endtask

  always @(posedge clk) begin
    for (int d = 0; d < 4; d++) req_snap[d] = o_req[d];
    #1;
    if (sb.size() > 0) begin
      mon_e = sb.pop_front();
      chk("gnt",       mon_e.sel, o_gnt[mon_e.sel],         mon_e.gnt);
      chk("gnt_idx",   mon_e.sel, {5'b0, o_idx[mon_e.sel]}, {5'b0, mon_e.idx});
      chk("gnt_valid", mon_e.sel, {7'b0, o_val[mon_e.sel]}, {7'b0, mon_e.valid});
      chk("hold_cnt",  mon_e.sel, {5'b0, o_hold[mon_e.sel]},{5'b0, mon_e.hold});
    end
    if (inv_on) begin
      for (int d = 0; d < 4; d++) begin
        chk("inv_onehot0", d, {7'b0, $onehot0(o_gnt[d])}, 8'h01);
        chk("inv_valid_or", d, {7'b0, o_val[d]}, {7'b0, |o_gnt[d]});
        if (o_val[d]) begin
          chk("inv_gnt_at_idx", d, {7'b0, o_gnt[d][o_idx[d]]}, 8'h01);
          chk("inv_req_prev", d, {7'b0, req_snap[d][o_idx[d]]}, 8'h01);
        end else begin
          chk("inv_idle_idx", d, {5'b0, o_idx[d]}, 8'h00);
        end
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached, %0d checks, %0d errors", checks, errors);
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] r;
    checks = 0;
    errors = 0;
    inv_on = 1'b0;
    rst_n  = 1'b0;
    req_fp = '0; req_r0 = '0; req_r4 = '0; req_r5 = '0;
    repeat (3) @(negedge clk);
    inv_on = 1'b1;

    // reset state, then reset while requester 4 holds the grant
    step(2, 1'b0, 8'h00, 1'b0, 3'd0, 3'd0);
    step(2, 1'b1, 8'h10, 1'b1, 3'd4, 3'd1);
    step(2, 1'b1, 8'h10, 1'b1, 3'd4, 3'd2);
    step(2, 1'b0, 8'h10, 1'b0, 3'd0, 3'd0);
    step(2, 1'b1, 8'h10, 1'b1, 3'd4, 3'd1);
    step(2, 1'b1, 8'h00, 1'b0, 3'd0, 3'd0);

    // fixed priority: lowest index wins, no forced rotation
    step(0, 1'b1, 8'hA4, 1'b1, 3'd2, 3'd1);
    for (int i = 0; i < 10; i++)
      step(0, 1'b1, 8'hA4, 1'b1, 3'd2, (i + 2 > 4) ? 3'd4 : 3'(i + 2));
    step(0, 1'b1, 8'hA0, 1'b1, 3'd5, 3'd1);
    step(0, 1'b1, 8'h00, 1'b0, 3'd0, 3'd0);

    // round-robin, unlimited hold, each owner drops after one cycle
    step(1, 1'b1, 8'hFF, 1'b1, 3'd0, 3'd1);
    for (int i = 1; i <= 8; i++) begin
      r = ~(8'h01 << ((i - 1) % 8));
      step(1, 1'b1, r, 1'b1, 3'(i % 8), 3'd1);
    end
    step(1, 1'b1, 8'h00, 1'b0, 3'd0, 3'd0);

    // hold limit 4 with two constant requesters
    for (int i = 0; i < 16; i++)
      step(2, 1'b1, 8'h03, 1'b1, 3'((i / 4) % 2), 3'(i % 4 + 1));
    step(2, 1'b1, 8'h00, 1'b0, 3'd0, 3'd0);

    // single requester is never rotated away
    for (int i = 0; i < 20; i++)
      step(2, 1'b1, 8'h80, 1'b1, 3'd7, (i + 1 > 4) ? 3'd4 : 3'(i + 1));
    step(2, 1'b1, 8'h00, 1'b0, 3'd0, 3'd0);

    // one-cycle request latency and release
    step(2, 1'b1, 8'h08, 1'b1, 3'd3, 3'd1);
    step(2, 1'b1, 8'h00, 1'b0, 3'd0, 3'd0);
    step(2, 1'b1, 8'h00, 1'b0, 3'd0, 3'd0);

    // N=5 round-robin wrap 4 -> 0
    step(3, 1'b1, 8'h1F, 1'b1, 3'd0, 3'd1);
    step(3, 1'b1, 8'h1F, 1'b1, 3'd0, 3'd1);
    for (int i = 1; i <= 5; i++) begin
      r = 8'h1F & ~(8'h01 << ((i - 1) % 5));
      step(3, 1'b1, r, 1'b1, 3'(i % 5), 3'd1);
    end
    step(3, 1'b1, 8'h00, 1'b0, 3'd0, 3'd0);

    // random requests, invariants only
    for (int i = 0; i < 300; i++) begin
      @(negedge clk);
      req_fp = 8'($urandom) & 8'($urandom);
      req_r0 = 8'($urandom) & 8'($urandom);
      req_r4 = 8'($urandom) & 8'($urandom);
      req_r5 = 5'($urandom) & 5'($urandom);
    end

    repeat (3) @(negedge clk);
    chk("scoreboard_drained", 0, 8'(sb.size()), 8'h00);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
